// File: rtl/audio_pkg.sv
// Shared types and widths for the audio filter scheduler.
package audio_pkg;

  localparam int unsigned CH_W  = 24;
  localparam int unsigned PCM_W = 16;
  localparam int unsigned AW    = 10;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StStart,
    StArm,
    StRun,
    StDone
  } sched_state_e;

  // Per-channel state-RAM base, truncated to the RAM address width.
  function automatic logic [AW-1:0] base_addr(input int unsigned ch, input int unsigned stride);
    return AW'(ch * stride);
  endfunction

endpackage

// File: rtl/audio_filter_sched_if.sv
// Filter-engine handshake plus state-RAM write port shared by scheduler and filter.
interface audio_filter_sched_if;

  logic                              flt_start;
  logic                              flt_busy;
  logic        [audio_pkg::AW-1:0]   flt_addr;
  logic        [audio_pkg::CH_W-1:0] flt_din;
  logic signed [audio_pkg::PCM_W-1:0] flt_out;
  logic                              flt_wr_en;
  logic        [audio_pkg::AW-1:0]   flt_wr_addr;
  logic        [audio_pkg::CH_W-1:0] flt_wr_data;
  logic                              mem_wr_en;
  logic        [audio_pkg::AW-1:0]   mem_wr_addr;
  logic        [audio_pkg::CH_W-1:0] mem_wr_data;

  modport master (
    output flt_start, flt_addr, flt_din, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  flt_busy, flt_out, flt_wr_en, flt_wr_addr, flt_wr_data
  );

  modport slave (
    input  flt_start, flt_addr, flt_din, mem_wr_en, mem_wr_addr, mem_wr_data,
    output flt_busy, flt_out, flt_wr_en, flt_wr_addr, flt_wr_data
  );

endinterface

// File: rtl/audio_state_clear.sv
// State-RAM zero-fill counter and write-port mux; built only with AUDIO_SCHED_CLEAR_EN.
module audio_state_clear
  import audio_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned STRIDE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            flt_busy_i,
  input  logic            flt_wr_en_i,
  input  logic [AW-1:0]   flt_wr_addr_i,
  input  logic [CH_W-1:0] flt_wr_data_i,
  output logic            mem_wr_en_o,
  output logic [AW-1:0]   mem_wr_addr_o,
  output logic [CH_W-1:0] mem_wr_data_o,
  output logic            done_o
);

  localparam logic [AW-1:0] LastAddr = AW'(NCH * STRIDE - 1);

  logic [AW-1:0] cnt_q;
  logic          run_q;
  logic          clr_wr;

  // The filter has no reset; hold off until it has finished any in-flight write.
  assign clr_wr = clear_i && !rst && (run_q || !flt_busy_i);
  assign done_o = clr_wr && (cnt_q == LastAddr);

  always_ff @(posedge clk) begin
    if (rst || !clear_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (clr_wr) begin
      cnt_q <= cnt_q + AW'(1);
      run_q <= 1'b1;
    end
  end

  always_comb begin
    mem_wr_en_o   = flt_wr_en_i;
    mem_wr_addr_o = flt_wr_addr_i;
    mem_wr_data_o = flt_wr_data_i;
    if (clear_i) begin
      mem_wr_en_o   = clr_wr;
      mem_wr_addr_o = cnt_q;
      mem_wr_data_o = '0;
    end
  end

endmodule

// File: rtl/audio_filter_sched.sv
// Multi-channel scheduler for the shared comb/DC filter engine.
// Define AUDIO_SCHED_CLEAR_EN to zero-fill the filter state RAM after reset.
module audio_filter_sched
  import audio_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned STRIDE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stb_pcm,
  input  logic [NCH*CH_W-1:0]    ch_data,
  audio_filter_sched_if.master   flt,
  output logic [NCH*PCM_W-1:0]   pcm_data,
  output logic                   pcm_valid,
  output logic                   overrun
);

  localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [ChW-1:0] ChLast = ChW'(NCH - 1);

`ifdef AUDIO_SCHED_CLEAR_EN
  localparam sched_state_e ResetState = StClear;
`else
  localparam sched_state_e ResetState = StIdle;
`endif

  sched_state_e                       state_q;
  logic [ChW-1:0]                     ch_q;
  logic [ChW-1:0]                     ch_nxt;
  logic [NCH-1:0][CH_W-1:0]           snap_q;
  logic [NCH-1:0][PCM_W-1:0]          frame_q;
  logic [NCH-1:0][PCM_W-1:0]          frame_d;
  logic [NCH-1:0][PCM_W-1:0]          pcm_data_q;
  logic                               flt_start_q;
  logic [AW-1:0]                      flt_addr_q;
  logic [CH_W-1:0]                    flt_din_q;
  logic                               pcm_valid_q;
  logic                               overrun_q;
  logic                               stb_ovr;
  logic                               clear_done;

  assign ch_nxt = ch_q + ChW'(1);

  assign stb_ovr = stb_pcm &&
                   ((state_q inside {StStart, StArm, StRun, StDone}) ||
                    (state_q == StIdle && flt.flt_busy));

  always_comb begin
    frame_d        = frame_q;
    frame_d[ch_q]  = flt.flt_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ResetState;
      ch_q        <= '0;
      snap_q      <= '0;
      frame_q     <= '0;
      pcm_data_q  <= '0;
      flt_start_q <= 1'b0;
      flt_addr_q  <= '0;
      flt_din_q   <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      flt_start_q <= 1'b0;
      pcm_valid_q <= 1'b0;
      if (stb_ovr) overrun_q <= 1'b1;
      case (state_q)
`ifdef AUDIO_SCHED_CLEAR_EN
        StClear: if (clear_done) state_q <= StIdle;
`endif
        StIdle: begin
          if (stb_pcm && !flt.flt_busy) begin
            snap_q      <= ch_data;
            ch_q        <= '0;
            flt_start_q <= 1'b1;
            flt_addr_q  <= '0;
            flt_din_q   <= ch_data[CH_W-1:0];
            state_q     <= StStart;
          end
        end
        StStart: state_q <= StArm;
        StArm:   if (flt.flt_busy) state_q <= StRun;
        StRun: begin
          if (!flt.flt_busy) begin
            frame_q <= frame_d;
            if (ch_q == ChLast) begin
              pcm_data_q  <= frame_d;
              pcm_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              ch_q        <= ch_nxt;
              flt_start_q <= 1'b1;
              flt_addr_q  <= base_addr(32'(ch_nxt), STRIDE);
              flt_din_q   <= snap_q[ch_nxt];
              state_q     <= StStart;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= ResetState;
      endcase
    end
  end

`ifdef AUDIO_SCHED_CLEAR_EN
  audio_state_clear #(
    .NCH    (NCH),
    .STRIDE (STRIDE)
  ) u_clear (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (state_q == StClear),
    .flt_busy_i    (flt.flt_busy),
    .flt_wr_en_i   (flt.flt_wr_en),
    .flt_wr_addr_i (flt.flt_wr_addr),
    .flt_wr_data_i (flt.flt_wr_data),
    .mem_wr_en_o   (flt.mem_wr_en),
    .mem_wr_addr_o (flt.mem_wr_addr),
    .mem_wr_data_o (flt.mem_wr_data),
    .done_o        (clear_done)
  );
`else
  assign clear_done      = 1'b0;
  assign flt.mem_wr_en   = flt.flt_wr_en;
  assign flt.mem_wr_addr = flt.flt_wr_addr;
  assign flt.mem_wr_data = flt.flt_wr_data;
`endif

  assign flt.flt_start = flt_start_q;
  assign flt.flt_addr  = flt_addr_q;
  assign flt.flt_din   = flt_din_q;
  assign pcm_data      = pcm_data_q;
  assign pcm_valid     = pcm_valid_q;
  assign overrun       = overrun_q;

endmodule
